// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//   Serializes host configuration words, MSB first, into a configuration
//   flop chain through ccff_head. After the load it can optionally
//   recirculate the chain once, feeding ccff_tail back to ccff_head. It
//   then compares a CRC-16-CCITT of the read-back stream against a CRC of
//   the loaded stream.
//
// Ports
//   prog_clk, prog_reset  configuration clock, synchronous active-high reset
//   start                 one-cycle load request, honoured only when idle
//   word_in, word_valid   host configuration word and its valid flag
//   word_ready            host word accepted when word_valid && word_ready
//   ccff_head             serial data into the chain
//   shift_en              chain captures ccff_head at the end of this cycle
//   ccff_tail             serial data returning from the end of the chain
//   busy                  high while loading or verifying
//   done                  one-cycle completion pulse
//   error                 read-back CRC mismatch, held until the next start
//   bit_count             bits shifted so far in the current pass
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8,
  parameter int VERIFY_EN = 1
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       bit_count
);

  localparam int              BL_W      = $clog2(WORD_W + 1);
  localparam logic [15:0]     LEN16     = 16'(CHAIN_LEN);
  localparam logic [15:0]     LAST16    = 16'(CHAIN_LEN - 1);
  localparam logic [BL_W-1:0] WORD_BITS = BL_W'(WORD_W);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY} state_t;

  state_t            state_q, state_n;
  logic [WORD_W-1:0] word_buf_q, word_buf_n;
  logic [BL_W-1:0]   bits_left_q, bits_left_n;
  logic [15:0]       bit_count_q, bit_count_n;
  logic [15:0]       crc_load_q, crc_load_n;
  logic [15:0]       crc_rb_q, crc_rb_n;
  logic              error_q, error_n;
  logic              done_q, done_n;
  logic              shift_en_q, shift_en_n;

  // CRC-16-CCITT (poly 0x1021), one bit per call.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign busy       = (state_q != IDLE);
  assign word_ready = (state_q == LOAD) && (bits_left_q == '0) && (bit_count_q < LEN16);
  assign shift_en   = shift_en_q;
  // The buffer MSB is a flop. It is cleared whenever the buffer empties,
  // so ccff_head idles at 0. During verify the tail loops straight back
  // to the head so the chain is restored after one full pass.
  assign ccff_head  = (state_q == VERIFY) ? ccff_tail : word_buf_q[WORD_W-1];
  assign done       = done_q;
  assign error      = error_q;
  assign bit_count  = bit_count_q;

  always_comb begin
    state_n     = state_q;
    word_buf_n  = word_buf_q;
    bits_left_n = bits_left_q;
    bit_count_n = bit_count_q;
    crc_load_n  = crc_load_q;
    crc_rb_n    = crc_rb_q;
    error_n     = error_q;
    done_n      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n     = LOAD;
          word_buf_n  = '0;
          bits_left_n = '0;
          bit_count_n = '0;
          crc_load_n  = 16'hFFFF;
          crc_rb_n    = 16'hFFFF;
          error_n     = 1'b0;
        end
      end
      LOAD: begin
        if (bits_left_q != '0) begin
          word_buf_n  = word_buf_q << 1;
          bits_left_n = bits_left_q - BL_W'(1);
          bit_count_n = bit_count_q + 16'd1;
          crc_load_n  = crc16_step(crc_load_q, word_buf_q[WORD_W-1]);
          if (bit_count_n == LEN16) begin
            // Chain is full: drop whatever is left of the current word.
            word_buf_n  = '0;
            bits_left_n = '0;
            if (VERIFY_EN != 0) begin
              state_n     = VERIFY;
              bit_count_n = '0;
            end else begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end else if (word_ready && word_valid) begin
          word_buf_n  = word_in;
          bits_left_n = WORD_BITS;
        end
      end
      VERIFY: begin
        bit_count_n = bit_count_q + 16'd1;
        crc_rb_n    = crc16_step(crc_rb_q, ccff_tail);
        if (bit_count_q == LAST16) begin
          state_n = IDLE;
          done_n  = 1'b1;
          error_n = (crc_rb_n != crc_load_q);
        end
      end
      default: state_n = IDLE;
    endcase
    // shift_en is a flop: it is high in the cycle after a shift is scheduled.
    shift_en_n = (state_n == VERIFY) || ((state_n == LOAD) && (bits_left_n != '0));
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      word_buf_q  <= '0;
      bits_left_q <= '0;
      bit_count_q <= '0;
      crc_load_q  <= 16'hFFFF;
      crc_rb_q    <= 16'hFFFF;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      shift_en_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      word_buf_q  <= word_buf_n;
      bits_left_q <= bits_left_n;
      bit_count_q <= bit_count_n;
      crc_load_q  <= crc_load_n;
      crc_rb_q    <= crc_rb_n;
      error_q     <= error_n;
      done_q      <= done_n;
      shift_en_q  <= shift_en_n;
    end
  end

endmodule
